fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register.
- Owns the PC and drives the instruction-memory request handshake.
- Presents decoded instruction fields (op_code, id_rs, id_rt, id_rd, id_function) to the decode-stage control unit.
- Honours that unit's load-use stall (its flush output) and squashes the wrong-path instruction on branch/jump redirects resolved in ID.

Parameters:
- PC_WIDTH, 32, PC and address width in bits.
- RESET_PC, 32'h0000_0000, byte address fetched after reset.
- NOP_INSTR, 32'h0000_0000, bubble encoding; op_code 0 decodes to all-zero controls.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- imem_req  output  1  fetch request; held until imem_ready.
- imem_addr  output  PC_WIDTH  byte address; stable while imem_req=1 and imem_ready=0.
- imem_data  input  32  instruction, valid when imem_ready=1.
- imem_ready  input  1  response strobe; ignored when imem_req=0.
- stall  input  1  load-use hazard from the control unit; hold IF/ID and PC.
- redirect  input  1  taken branch/jump resolved in ID.
- redirect_target  input  PC_WIDTH  new PC; bits [1:0] forced to 0.
- id_instr  output  32  IF/ID instruction.
- id_pc4  output  PC_WIDTH  IF/ID PC+4, used for jal link and branch base.
- id_valid  output  1  IF/ID holds a real instruction.
- op_code  output  6  id_instr[31:26].
- id_rs  output  5  id_instr[25:21].
- id_rt  output  5  id_instr[20:16].
- id_rd  output  5  id_instr[15:11].
- id_function  output  6  id_instr[5:0].
- id_imm  output  16  id_instr[15:0].

Behaviour:
- Reset (async):
  - pc=RESET_PC, state=S_REQ, buffer empty.
  - id_instr=NOP_INSTR, id_pc4=0, id_valid=0.
  - imem_req=0 while rst is high; first request in the cycle after deassertion.
- Field outputs are combinational slices of the id_instr register.
- States:
  - S_REQ: imem_req=1, imem_addr=pc.
  - S_DRAIN: imem_req=1 at the abandoned address; response discarded.
  - S_HOLD: imem_req=0; 1-entry skid buffer full.
- Priority per cycle: stall > redirect > normal. Redirect under stall is ignored; the branch is re-presented once stall drops.
- S_REQ, imem_ready=1:
  - stall=0: IF/ID <= {imem_data, pc+4, valid=1}; pc <= pc+4; stay in S_REQ. Back-to-back fetch gives 1 instruction/cycle at zero wait.
  - stall=1: capture {imem_data, pc+4} in the buffer; pc <= pc+4; go S_HOLD; IF/ID held.
- S_REQ, imem_ready=0:
  - stall=0: IF/ID <= bubble (NOP_INSTR, valid=0).
  - stall=1: IF/ID held.
- S_HOLD, stall=0: IF/ID <= buffer, valid=1; buffer cleared; go S_REQ.
- Redirect (stall=0), fixed 1-cycle penalty in all cases:
  - IF/ID <= bubble; buffer cleared.
  - S_REQ with imem_ready=1, or S_HOLD: pc <= target; go S_REQ.
  - S_REQ with imem_ready=0: latch target in pend_pc; go S_DRAIN. imem_addr stays unchanged; the handshake is never broken.
- S_DRAIN:
  - On imem_ready: discard data; pc <= pend_pc; go S_REQ.
  - A second redirect overwrites pend_pc (last wins).
  - IF/ID <= bubble unless stall.
- PC arithmetic is modulo 2^PC_WIDTH; wrap from all-ones to 0 is legal and silent.
- Reset mid-transaction abandons any outstanding request; memory must tolerate req dropping on reset.
- Invariants:
  - id_valid=0 implies id_instr=NOP_INSTR.
  - imem_req never falls without imem_ready, except on reset or entering S_HOLD (which only happens with imem_ready).

Decomposition:
- Shared package cpu_pkg:
  - fetch state enum (S_REQ, S_DRAIN, S_HOLD).
  - NOP_INSTR.
  - instruction field bit positions (OPC_MSB/LSB, RS, RT, RD, FUNCT, IMM).
  - opcode constants shared with the control unit (R=6'h01, beq=6'h05, bne=6'h04, j=6'h02, jal=6'h03, lw=6'h12, ...).
- One sub-module: if_id_reg, holding the instruction/pc4/valid flops with load, hold and bubble controls. Field slicing lives there.
- PC, FSM and skid buffer stay in fetch_stage.

Test Plan:
- Reset, imem_ready tied 1: addrs 0x0, 0x4, 0x8 on consecutive cycles; id_pc4 = 0x4, 0x8, 0xC one cycle later; id_valid=1 from the 2nd cycle.
- imem_data=32'h0123_4820 in IF/ID: op_code=0, id_rs=9, id_rt=3, id_rd=9, id_function=6'h20, id_imm=16'h4820.
- stall high 2 cycles with ready=1: IF/ID unchanged; one word buffered, then imem_req=0; after release, buffered word appears next cycle; no word lost or duplicated.
- redirect=1, target=0x103 at pc 0x20: imem_addr=0x100 next cycle; IF/ID bubble (valid=0, instr 0) for exactly 1 cycle.
- imem_ready low 3 cycles, redirect to 0x200 in wait cycle 1: imem_addr stays at the old addr until ready; old data dropped; next request at 0x200.
- stall and redirect together: redirect ignored; pc and IF/ID held. Re-asserted redirect after stall takes effect.
- rst pulsed during S_DRAIN: outputs return to reset values asynchronously; first request after release is at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline slice.
// Holds the fetch-stage state encoding, the bubble encoding, instruction field
// bit positions and the opcode constants shared with the decode control unit.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

  // Bubble: opcode 0 decodes to all-zero controls.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int unsigned OPC_MSB   = 31;
  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned IMM_MSB   = 15;
  localparam int unsigned IMM_LSB   = 0;

  localparam logic [5:0] OP_R   = 6'h01;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BNE = 6'h04;
  localparam logic [5:0] OP_BEQ = 6'h05;
  localparam logic [5:0] OP_LW  = 6'h12;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Holds the fetched instruction, its PC+4 and a valid flag, and slices the
// decode fields out of the held instruction.
//   load       : capture load_instr/load_pc4 and mark valid
//   bubble     : replace the instruction with NOP_INSTR and clear valid
//   neither    : hold
//   id_*       : registered instruction, PC+4, valid and field slices
module if_id_reg #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                bubble,
  input  logic [31:0]         load_instr,
  input  logic [PC_WIDTH-1:0] load_pc4,
  output logic [31:0]         id_instr,
  output logic [PC_WIDTH-1:0] id_pc4,
  output logic                id_valid,
  output logic [5:0]          op_code,
  output logic [4:0]          id_rs,
  output logic [4:0]          id_rt,
  output logic [4:0]          id_rd,
  output logic [5:0]          id_function,
  output logic [15:0]         id_imm
);
  import cpu_pkg::*;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_instr <= NOP_INSTR;
      id_pc4   <= '0;
      id_valid <= 1'b0;
    end else if (load) begin
      id_instr <= load_instr;
      id_pc4   <= load_pc4;
      id_valid <= 1'b1;
    end else if (bubble) begin
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end
  end

  assign op_code     = id_instr[OPC_MSB:OPC_LSB];
  assign id_rs       = id_instr[RS_MSB:RS_LSB];
  assign id_rt       = id_instr[RT_MSB:RT_LSB];
  assign id_rd       = id_instr[RD_MSB:RD_LSB];
  assign id_function = id_instr[FUNCT_MSB:FUNCT_LSB];
  assign id_imm      = id_instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage.
// Owns the PC, runs the instruction-memory request handshake, buffers one
// word while decode is stalled and squashes the wrong-path fetch on redirect.
//   clk, rst                 : clock, asynchronous active-high reset
//   imem_req/addr/data/ready : instruction-memory handshake (req held until ready)
//   stall                    : load-use hold of PC and IF/ID
//   redirect/redirect_target : taken branch/jump resolved in ID
//   id_*, op_code            : IF/ID contents and decoded fields
module fetch_stage #(
  parameter int unsigned          PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter logic [31:0]          NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  input  logic                imem_ready,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_target,
  output logic [31:0]         id_instr,
  output logic [PC_WIDTH-1:0] id_pc4,
  output logic                id_valid,
  output logic [5:0]          op_code,
  output logic [4:0]          id_rs,
  output logic [4:0]          id_rt,
  output logic [4:0]          id_rd,
  output logic [5:0]          id_function,
  output logic [15:0]         id_imm
);
  import cpu_pkg::*;

  fetch_state_t        state, state_n;
  logic                req_en;
  logic [PC_WIDTH-1:0] pc, pc_n, pc4;
  logic [PC_WIDTH-1:0] pend_pc, pend_pc_n;
  logic [PC_WIDTH-1:0] tgt;
  logic [31:0]         buf_instr, buf_instr_n;
  logic [PC_WIDTH-1:0] buf_pc4, buf_pc4_n;
  logic                ifid_load, ifid_bubble;
  logic [31:0]         ifid_instr;
  logic [PC_WIDTH-1:0] ifid_pc4;

  assign pc4 = pc + PC_WIDTH'(4);
  assign tgt = redirect_target & ~PC_WIDTH'(3);

  // req_en keeps the request low through reset and starts fetching one cycle
  // after deassertion; all state transitions are gated by it.
  assign imem_req  = req_en && (state != S_HOLD);
  // In S_DRAIN pc still holds the abandoned address, so the address stays put.
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_REQ;
      req_en    <= 1'b0;
      pc        <= RESET_PC;
      pend_pc   <= '0;
      buf_instr <= NOP_INSTR;
      buf_pc4   <= '0;
    end else begin
      state     <= state_n;
      req_en    <= 1'b1;
      pc        <= pc_n;
      pend_pc   <= pend_pc_n;
      buf_instr <= buf_instr_n;
      buf_pc4   <= buf_pc4_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    pend_pc_n   = pend_pc;
    buf_instr_n = buf_instr;
    buf_pc4_n   = buf_pc4;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_instr  = imem_data;
    ifid_pc4    = pc4;
    if (req_en) begin
      unique case (state)
        S_REQ: begin
          if (stall) begin
            // Decode is frozen: park the returning word in the skid buffer.
            if (imem_ready) begin
              buf_instr_n = imem_data;
              buf_pc4_n   = pc4;
              pc_n        = pc4;
              state_n     = S_HOLD;
            end
          end else if (redirect) begin
            ifid_bubble = 1'b1;
            if (imem_ready) begin
              pc_n = tgt;
            end else begin
              // Request in flight: finish it before moving to the target.
              pend_pc_n = tgt;
              state_n   = S_DRAIN;
            end
          end else if (imem_ready) begin
            ifid_load = 1'b1;
            pc_n      = pc4;
          end else begin
            ifid_bubble = 1'b1;
          end
        end
        S_DRAIN: begin
          if (imem_ready) begin
            pc_n    = pend_pc;
            state_n = S_REQ;
          end
          if (!stall) begin
            ifid_bubble = 1'b1;
            // A newer redirect wins, including one arriving with the response.
            if (redirect) begin
              if (imem_ready) pc_n = tgt;
              else            pend_pc_n = tgt;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            state_n = S_REQ;
            if (redirect) begin
              ifid_bubble = 1'b1;
              pc_n        = tgt;
            end else begin
              ifid_load  = 1'b1;
              ifid_instr = buf_instr;
              ifid_pc4   = buf_pc4;
            end
          end
        end
        default: state_n = S_REQ;
      endcase
    end
  end

  if_id_reg #(
    .PC_WIDTH  (PC_WIDTH),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (ifid_load),
    .bubble      (ifid_bubble),
    .load_instr  (ifid_instr),
    .load_pc4    (ifid_pc4),
    .id_instr    (id_instr),
    .id_pc4      (id_pc4),
    .id_valid    (id_valid),
    .op_code     (op_code),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .id_function (id_function),
    .id_imm      (id_imm)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk, rst;
  logic        imem_req, imem_ready, stall, redirect, id_valid;
  logic [31:0] imem_addr, imem_data, redirect_target, id_instr, id_pc4;
  logic [5:0]  op_code, id_function;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  fetch_stage #(
    .PC_WIDTH  (32),
    .RESET_PC  (32'h0),
    .NOP_INSTR (32'h0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .imem_ready      (imem_ready),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .id_instr        (id_instr),
    .id_pc4          (id_pc4),
    .id_valid        (id_valid),
    .op_code         (op_code),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .id_function     (id_function),
    .id_imm          (id_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h8) return 32'h0123_4820;
    return {16'hBEEF ^ a[31:16], a[15:0]};
  endfunction

  assign imem_data = mem(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_q.push_back({mem(a), a + 32'd4});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: decode consumes IF/ID in any cycle where it is valid and not stalled.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      if (!id_valid) chk("bubble_is_nop", id_instr, 32'h0);
      if (id_valid && !stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_extra: got instr %h pc4 %h expected nothing", id_instr, id_pc4);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr", id_instr, e[63:32]);
          chk("sb_pc4", id_pc4, e[31:0]);
          chk("sb_fields", {5'd0, op_code, id_rs, id_rt, id_rd, id_function},
              {5'd0, e[63:58], e[57:53], e[52:48], e[47:43], e[37:32]});
          chk("sb_imm", {16'd0, id_imm}, {16'd0, e[47:32]});
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; imem_ready = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
    #1;
    chk("rst_req", imem_req, 32'd0);
    chk("rst_valid", id_valid, 32'd0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc4", id_pc4, 32'h0);
    repeat (2) @(posedge clk);
    #1 chk("rst_req_held", imem_req, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("req_after_release", imem_req, 32'd0);

    // Streaming at zero wait
    step(); chk("s0_req", imem_req, 32'd1); chk("s0_addr", imem_addr, 32'h0); push(32'h0);
    step(); chk("s1_addr", imem_addr, 32'h4); chk("s1_pc4", id_pc4, 32'h4);
    chk("s1_valid", id_valid, 32'd1); push(32'h4);
    step(); chk("s2_addr", imem_addr, 32'h8); chk("s2_pc4", id_pc4, 32'h8); push(32'h8);
    step();
    chk("f_op", {26'd0, op_code}, 32'd0);
    chk("f_rs", {27'd0, id_rs}, 32'd9);
    chk("f_rt", {27'd0, id_rt}, 32'd3);
    chk("f_rd", {27'd0, id_rd}, 32'd9);
    chk("f_funct", {26'd0, id_function}, 32'h20);
    chk("f_imm", {16'd0, id_imm}, 32'h4820);
    chk("s3_pc4", id_pc4, 32'hC);

    // Stall two cycles with ready=1
    stall = 1'b1;
    step(); chk("st1_req", imem_req, 32'd0); chk("st1_hold", id_instr, 32'h0123_4820);
    step(); chk("st2_req", imem_req, 32'd0); chk("st2_hold", id_pc4, 32'hC);
    stall = 1'b0; push(32'hC);
    step(); chk("unst_instr", id_instr, mem(32'hC)); chk("unst_req", imem_req, 32'd1);
    chk("unst_addr", imem_addr, 32'h10); push(32'h10);
    step(); push(32'h14);
    step(); push(32'h18);
    step(); push(32'h1C);
    step(); chk("br_addr", imem_addr, 32'h20);

    // Redirect at zero wait
    redirect = 1'b1; redirect_target = 32'h103;
    step(); redirect = 1'b0;
    chk("rd_addr", imem_addr, 32'h100); chk("rd_valid", id_valid, 32'd0);
    chk("rd_instr", id_instr, 32'h0); push(32'h100);
    step(); chk("rd_one_bubble", id_valid, 32'd1);

    // Redirect while the request waits
    imem_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h200;
    step(); redirect = 1'b0;
    chk("dr1_addr", imem_addr, 32'h104); chk("dr1_req", imem_req, 32'd1);
    chk("dr1_valid", id_valid, 32'd0);
    step(); chk("dr2_addr", imem_addr, 32'h104); chk("dr2_req", imem_req, 32'd1);
    step(); chk("dr3_addr", imem_addr, 32'h104);
    imem_ready = 1'b1;
    step(); chk("dr_new_addr", imem_addr, 32'h200); chk("dr_valid", id_valid, 32'd0); push(32'h200);
    step(); chk("dr_next_addr", imem_addr, 32'h204);

    // Stall and redirect together
    stall = 1'b1; redirect = 1'b1; redirect_target = 32'h300;
    step(); chk("sr1_req", imem_req, 32'd0); chk("sr1_hold", id_instr, mem(32'h200));
    step(); chk("sr2_pc", imem_addr, 32'h208); chk("sr2_hold", id_instr, mem(32'h200));
    chk("sr2_valid", id_valid, 32'd1);
    stall = 1'b0;
    step(); redirect = 1'b0;
    chk("sr_req", imem_req, 32'd1); chk("sr_addr", imem_addr, 32'h300);
    chk("sr_valid", id_valid, 32'd0); push(32'h300);
    step(); chk("sr_instr", id_instr, mem(32'h300));

    // Reset pulsed in S_DRAIN
    imem_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h400;
    step(); redirect = 1'b0; chk("rd2_addr", imem_addr, 32'h304);
    #2 rst = 1'b1; #1;
    chk("ar_req", imem_req, 32'd0); chk("ar_valid", id_valid, 32'd0);
    chk("ar_instr", id_instr, 32'h0); chk("ar_pc4", id_pc4, 32'h0);
    @(negedge clk); rst = 1'b0; imem_ready = 1'b1; #1;
    chk("ar_req_release", imem_req, 32'd0);
    step(); chk("ar_first_req", imem_req, 32'd1); chk("ar_first_addr", imem_addr, 32'h0); push(32'h0);
    step(); chk("ar_pc4_after", id_pc4, 32'h4);
    imem_ready = 1'b0;
    step(); step();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
